// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: three writeback requesters, the issue-side
// destination reservation, operand-pending queries, flush and the
// register-file write port, bundled so the arbiter takes one port.
interface regfile_wb_arbiter_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [63:0] ex_data;

    logic        ls_valid;
    logic        ls_ready;
    logic [4:0]  ls_rd;
    logic [63:0] ls_data;

    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [63:0] md_data;

    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;

    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_busy;
    logic        rs2_busy;

    logic        flush;

    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    modport slave (
        input  ex_valid, ex_rd, ex_data,
        input  ls_valid, ls_rd, ls_data,
        input  md_valid, md_rd, md_data,
        input  iss_valid, iss_rd,
        input  q_rs1, q_rs2,
        input  flush,
        output ex_ready, ls_ready, md_ready,
        output iss_ready,
        output rs1_busy, rs2_busy,
        output rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output ex_valid, ex_rd, ex_data,
        output ls_valid, ls_rd, ls_data,
        output md_valid, md_rd, md_data,
        output iss_valid, iss_rd,
        output q_rs1, q_rs2,
        output flush,
        input  ex_ready, ls_ready, md_ready,
        input  iss_ready,
        input  rs1_busy, rs2_busy,
        input  rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ex -> ls -> md) driving a single
// register-file write port one cycle after each accept, plus a 32-entry
// pending-destination scoreboard shared with issue.
module regfile_wb_arbiter (
    input  logic                  clock,
    input  logic                  reset_n,
    regfile_wb_arbiter_if.slave   bus
);

    logic [1:0]  ptr_q, ptr_d;
    logic [31:0] pending_q, pending_d;
    logic        rf_wen_q, rf_wen_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [63:0] rf_wdata_q, rf_wdata_d;

    logic [2:0]  valid_vec;
    logic [2:0]  grant;
    logic        arb_open;
    logic        accept;
    logic [4:0]  acc_rd;
    logic [63:0] acc_data;
    logic        iss_ok;
    logic        iss_hs;

    assign valid_vec = {bus.md_valid, bus.ls_valid, bus.ex_valid};
    assign arb_open  = reset_n && !bus.flush;

    // Pick the first valid requester at or after the priority pointer.
    always_comb begin
        grant = 3'b000;
        if (arb_open) begin
            case (ptr_q)
                2'd0: begin
                    if      (valid_vec[0]) grant = 3'b001;
                    else if (valid_vec[1]) grant = 3'b010;
                    else if (valid_vec[2]) grant = 3'b100;
                end
                2'd1: begin
                    if      (valid_vec[1]) grant = 3'b010;
                    else if (valid_vec[2]) grant = 3'b100;
                    else if (valid_vec[0]) grant = 3'b001;
                end
                default: begin
                    if      (valid_vec[2]) grant = 3'b100;
                    else if (valid_vec[0]) grant = 3'b001;
                    else if (valid_vec[1]) grant = 3'b010;
                end
            endcase
        end
    end

    assign bus.ex_ready = grant[0];
    assign bus.ls_ready = grant[1];
    assign bus.md_ready = grant[2];
    assign accept       = |grant;

    // Select the winning request's destination and data; advance the pointer past the winner.
    always_comb begin
        acc_rd   = 5'd0;
        acc_data = 64'd0;
        ptr_d    = ptr_q;
        if (grant[0]) begin
            acc_rd   = bus.ex_rd;
            acc_data = bus.ex_data;
            ptr_d    = 2'd1;
        end else if (grant[1]) begin
            acc_rd   = bus.ls_rd;
            acc_data = bus.ls_data;
            ptr_d    = 2'd2;
        end else if (grant[2]) begin
            acc_rd   = bus.md_rd;
            acc_data = bus.md_data;
            ptr_d    = 2'd0;
        end
    end

    // Issue may reserve a destination only if nothing is in flight to it; x0 is never pending.
    assign iss_ok        = !pending_q[bus.iss_rd];
    assign bus.iss_ready = reset_n && !bus.flush && iss_ok;
    assign iss_hs        = bus.iss_valid && bus.iss_ready;

    assign bus.rs1_busy  = pending_q[bus.q_rs1];
    assign bus.rs2_busy  = pending_q[bus.q_rs2];

    // Scoreboard update: writeback clears, issue sets (set wins on a collision), flush wipes all.
    always_comb begin
        pending_d = pending_q;
        if (bus.flush) begin
            pending_d = 32'd0;
        end else begin
            if (accept) begin
                pending_d[acc_rd] = 1'b0;
            end
            if (iss_hs && (bus.iss_rd != 5'd0)) begin
                pending_d[bus.iss_rd] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // Write-port next state: strobe only for a non-x0 accept; address/data hold between accepts.
    always_comb begin
        rf_wen_d   = accept && (acc_rd != 5'd0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (accept) begin
            rf_waddr_d = acc_rd;
            rf_wdata_d = acc_data;
        end
    end

    // State registers; reset also drops any write already scheduled for the next cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q      <= 2'd0;
            pending_q  <= 32'd0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 64'd0;
        end else begin
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL expose clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-003 SHALL expose, per requester k in {ex, ls, md}: k_valid in 1, k_ready out 1, k_rd in 5, k_data in 64, forming the writeback request handshake.
REQ-004 SHALL expose iss_valid in 1, iss_rd in 5, iss_ready out 1 as the scoreboard destination-reservation handshake from issue.
REQ-005 SHALL expose q_rs1 in 5, q_rs2 in 5, rs1_busy out 1, rs2_busy out 1 as the operand-pending query.
REQ-006 SHALL expose flush in 1 as the pipeline flush request.
REQ-007 SHALL expose rf_wen out 1, rf_waddr out 5, rf_wdata out 64 as the register-file write-port drive.

Function
REQ-008 SHALL transfer a writeback on requester k in any cycle with k_valid=1 and k_ready=1 (the accept cycle).
REQ-009 SHALL assert at most one k_ready per cycle; k_ready SHALL be combinational from the valids, the priority pointer and flush.
REQ-010 SHALL arbitrate round-robin over the order ex(0) -> ls(1) -> md(2); the highest-priority valid requester starting at pointer ptr wins.
REQ-011 SHALL set ptr to (k+1) mod 3 after an accept from requester k; ptr SHALL hold when no accept occurs.
REQ-012 SHALL hold k_ready low for every requester while k_valid=0 (no grant to idle requesters).
REQ-013 SHALL, one cycle after the accept cycle, drive rf_wen=1, rf_waddr=k_rd, rf_wdata=k_data (fixed latency of 1).
REQ-014 SHALL accept a writeback with k_rd=0 normally, but drive rf_wen=0 in the following cycle.
REQ-015 SHALL drive rf_wen=0 in every cycle not following an accept; rf_waddr/rf_wdata SHALL hold their last values.
REQ-016 SHALL maintain a 32-bit pending vector; bit 0 SHALL be constantly 0.
REQ-017 SHALL drive iss_ready = !pending[iss_rd] && !flush; iss_rd=0 SHALL always be ready.
REQ-018 SHALL set pending[iss_rd] on an issue handshake with iss_rd!=0.
REQ-019 SHALL clear pending[k_rd] in the writeback accept cycle.
REQ-020 SHALL give set priority when an issue set and a writeback clear target the same register in one cycle.
REQ-021 SHALL drive rsN_busy = pending[q_rsN] from current register state, with no same-cycle bypass of issue or writeback.
REQ-022 SHALL, while flush=1: hold all k_ready low, hold iss_ready low, and clear every pending bit at the clock edge.
REQ-023 SHALL complete a write-port drive already scheduled by a pre-flush accept in the cycle after the accept, regardless of flush.
REQ-024 SHALL NOT let a requester drop k_valid or change k_rd/k_data while k_valid=1 and k_ready=0; a violation SHALL be ignored (no check logic).

Reset
REQ-025 SHALL, in any cycle with reset_n=0, force at the edge: rf_wen=0, rf_waddr=0, rf_wdata=0, pending=0, ptr=0.
REQ-026 SHALL drive all k_ready and iss_ready low while reset_n=0, so no accept or issue occurs during reset.
REQ-027 SHALL discard a write-port drive scheduled by an accept in the cycle before reset asserts (rf_wen=0 after the reset edge).
REQ-028 SHALL leave rs1_busy/rs2_busy at 0 for every query in the first cycle after reset_n rises.

Verification
REQ-029 Round-robin: ex, ls and md valid continuously, ptr=0 -> grants ex, ls, md, ex on cycles 1-4; rf_waddr follows each k_rd with 1-cycle lag.
REQ-030 Write port: ls accepts rd=5, data=0x1234_5678_9ABC_DEF0 in cycle N -> cycle N+1 shows rf_wen=1, waddr=5, data=0x1234_5678_9ABC_DEF0; cycle N+2 shows rf_wen=0.
REQ-031 x0: md accepts rd=0, data=0xFFFF_FFFF_FFFF_FFFF -> rf_wen stays 0; iss_rd=0 -> iss_ready=1 and rs1_busy for q_rs1=0 stays 0.
REQ-032 Scoreboard: issue rd=7 -> next cycle rs2_busy=1 for q_rs2=7 and iss_ready=0 for rd=7; ex writeback of rd=7 -> busy 0 the cycle after; same-cycle issue and writeback of rd=9 -> pending[9]=1.
REQ-033 Flush: pending {3,4} set, ex accept rd=3 in cycle N, flush=1 in cycle N+1 -> rf_wen=1, waddr=3 in N+1, all ready low in N+1, pending=0 from N+2.
REQ-034 Reset mid-operation: accept rd=12 in cycle N, reset_n=0 in N+1 -> rf_wen=0, rf_waddr=0 after the edge, ptr=0, all busy 0 after release.
